// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared CLINT register offsets, reset constants, FSM states and byte-merge helper
package clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - 64-bit mtime counter with byte-lane write port and registered compare (CLINT_PRESCALE_EN adds a tick prescaler)
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  wr_lo_be,
    input  logic [3:0]  wr_hi_be,
    input  logic [31:0] wdata,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtime,
    output logic        mtimer_irq
);

    logic tick;
    logic mtime_wr;

`ifdef CLINT_PRESCALE_EN
    logic [31:0] pre_cnt;

    assign tick = (pre_cnt == 32'(PRESCALE - 1));

    // Free-running divider; mtime writes deliberately leave its phase alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 32'd1;
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^PRESCALE;
`endif

    assign mtime_wr = (|wr_lo_be) || (|wr_hi_be);

    // A CPU write suppresses the increment for the whole 64-bit counter that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (mtime_wr) begin
            mtime <= {merge_bytes(mtime[63:32], wdata, wr_hi_be),
                      merge_bytes(mtime[31:0],  wdata, wr_lo_be)};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtimer_irq <= 1'b0;
        end else begin
            mtimer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: bus decode, handshake FSM, msip, mtimecmp and read mux (CLINT_PRESCALE_EN enables timer prescaler)
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_select,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        msw_irq,
    output logic        mtimer_irq
);

    state_t      state;
    state_t      state_next;
    logic        hit;
    logic [15:0] offset;
    logic        access;
    logic        do_write;
    logic        do_read;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [31:0] rd_mux;
    logic [3:0]  mtime_lo_be;
    logic [3:0]  mtime_hi_be;
    logic        unused_addr;

    assign hit         = (addr[31:16] == BASE_ADDR[31:16]) && (ren || wen);
    assign offset      = {addr[15:2], 2'b00};
    assign unused_addr = ^addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Simultaneous ren and wen is a write; the read path stays quiet.
    assign access   = (state == IDLE) && hit;
    assign do_write = access && wen;
    assign do_read  = access && ren && !wen;

    assign mtime_lo_be = (do_write && offset == MTIME_LO_OFF) ? byte_select : 4'b0000;
    assign mtime_hi_be = (do_write && offset == MTIME_HI_OFF) ? byte_select : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msip <= 1'b0;
        end else if (do_write && offset == MSIP_OFF && byte_select[0]) begin
            msip <= wdata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (do_write && offset == MTIMECMP_LO_OFF) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata, byte_select);
        end else if (do_write && offset == MTIMECMP_HI_OFF) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, byte_select);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            MSIP_OFF:        rd_mux = {31'b0, msip};
            MTIMECMP_LO_OFF: rd_mux = mtimecmp[31:0];
            MTIMECMP_HI_OFF: rd_mux = mtimecmp[63:32];
            MTIME_LO_OFF:    rd_mux = mtime[31:0];
            MTIME_HI_OFF:    rd_mux = mtime[63:32];
            default:         rd_mux = '0;
        endcase
    end

    // Captured from pre-write values; held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (do_read) begin
            rdata <= rd_mux;
        end
    end

    assign msw_irq = msip;

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_lo_be   (mtime_lo_be),
        .wr_hi_be   (mtime_hi_be),
        .wdata      (wdata),
        .mtimecmp   (mtimecmp),
        .mtime      (mtime),
        .mtimer_irq (mtimer_irq)
    );

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - self-checking bench for clint against a cycle-count reference model
module tb_clint;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  byte_select = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        msw_irq;
    logic        mtimer_irq;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [63:0] m_base;
    int          m_edge;
    logic [63:0] cmp_m;
    logic        msip_m;
    logic [31:0] last_rd;

    clint dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .ren         (ren),
        .wen         (wen),
        .byte_select (byte_select),
        .rdata       (rdata),
        .ready       (ready),
        .msw_irq     (msw_irq),
        .mtimer_irq  (mtimer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mtime after clock edge k: last written value plus one per elapsed edge.
    function automatic logic [63:0] mt(input int k);
        return m_base + 64'(k - m_edge);
    endfunction

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_base  = '0;
        m_edge  = cyc;
        cmp_m   = 64'hFFFF_FFFF_FFFF_FFFF;
        msip_m  = 1'b0;
        last_rd = '0;
    endtask

    task automatic chk_irq_now(input string tag);
        chk(tag, {63'b0, mtimer_irq}, {63'b0, mt(cyc - 1) >= cmp_m});
    endtask

    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic r, input logic w);
        logic [15:0] off;
        logic        is_hit;
        int          k;
        logic [31:0] exp_rd;
        logic [63:0] v;
        off    = a[15:0] & 16'hFFFC;
        is_hit = (a[31:16] == 16'h0200) && (r || w);
        addr = a; wdata = d; byte_select = be; ren = r; wen = w;
        @(posedge clk);
        #1;
        k = cyc;
        @(negedge clk);
        if (is_hit) begin
            chk("ready", {63'b0, ready}, 64'd1);
            v = mt(k - 1);
            exp_rd = last_rd;
            if (r && !w) begin
                case (off)
                    16'h0000: exp_rd = {31'b0, msip_m};
                    16'h4000: exp_rd = cmp_m[31:0];
                    16'h4004: exp_rd = cmp_m[63:32];
                    16'hBFF8: exp_rd = v[31:0];
                    16'hBFFC: exp_rd = v[63:32];
                    default:  exp_rd = 32'h0;
                endcase
            end
            chk("rdata", {32'b0, rdata}, {32'b0, exp_rd});
            last_rd = exp_rd;
            chk("irq_at_resp", {63'b0, mtimer_irq}, {63'b0, v >= cmp_m});
            if (w) begin
                case (off)
                    16'h0000: if (be[0]) msip_m = d[0];
                    16'h4000: cmp_m[31:0]  = bmerge(cmp_m[31:0], d, be);
                    16'h4004: cmp_m[63:32] = bmerge(cmp_m[63:32], d, be);
                    16'hBFF8: if (be != 4'b0) begin v[31:0]  = bmerge(v[31:0], d, be);  m_base = v; m_edge = k; end
                    16'hBFFC: if (be != 4'b0) begin v[63:32] = bmerge(v[63:32], d, be); m_base = v; m_edge = k; end
                    default: ;
                endcase
            end
            chk("msw_irq", {63'b0, msw_irq}, {63'b0, msip_m});
        end else begin
            chk("miss_ready", {63'b0, ready}, 64'd0);
        end
        ren = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1;
        if (!is_hit) chk("miss_ready2", {63'b0, ready}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [15:0] offs [0:5];
        offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
        offs[3] = 16'hBFF8; offs[4] = 16'hBFFC; offs[5] = 16'h1234;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'b0, ready}, 64'd0);
        chk("rst_rdata", {32'b0, rdata}, 64'd0);
        chk("rst_mtimer", {63'b0, mtimer_irq}, 64'd0);
        chk("rst_msw", {63'b0, msw_irq}, 64'd0);
        reset = 1'b0;
        model_reset();
        idle(10);
        xact(32'h0200_BFF8, 0, 4'h0, 1, 0);
        chk("idle10_mtime", {32'b0, rdata}, 64'd10);
        xact(32'h0200_4000, 0, 4'h0, 1, 0);
        xact(32'h0200_4004, 0, 4'h0, 1, 0);
        chk_irq_now("irq_idle");

        // Software interrupt
        xact(32'h0200_0000, 32'h1, 4'b0001, 0, 1);
        chk("msw_set", {63'b0, msw_irq}, 64'd1);
        xact(32'h0200_0000, 32'h0, 4'b0001, 0, 1);
        chk("msw_clr", {63'b0, msw_irq}, 64'd0);
        xact(32'h0200_0000, 32'h1, 4'b0000, 0, 1);
        xact(32'h0200_0000, 0, 4'h0, 1, 0);

        // Carry and wrap
        xact(32'h0200_BFFC, 32'h0, 4'hF, 0, 1);
        xact(32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, 0, 1);
        xact(32'h0200_BFF8, 0, 4'h0, 1, 0);
        xact(32'h0200_BFFC, 0, 4'h0, 1, 0);
        chk("carry_hi", {32'b0, rdata}, 64'd1);
        xact(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 0, 1);
        xact(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 0, 1);
        xact(32'h0200_BFF8, 0, 4'h0, 1, 0);
        chk("wrap_lo", {32'b0, rdata}, 64'd0);
        xact(32'h0200_BFFC, 0, 4'h0, 1, 0);

        // Timer compare rise and fall
        xact(32'h0200_4004, 32'h0, 4'hF, 0, 1);
        xact(32'h0200_4000, 32'd100, 4'hF, 0, 1);
        xact(32'h0200_BFFC, 32'h0, 4'hF, 0, 1);
        xact(32'h0200_BFF8, 32'd95, 4'hF, 0, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("irq_rise", {63'b0, mtimer_irq}, {63'b0, mt(cyc - 1) >= cmp_m});
        end
        #1;
        chk("irq_high", {63'b0, mtimer_irq}, 64'd1);
        xact(32'h0200_4004, 32'h1, 4'hF, 0, 1);
        chk_irq_now("irq_fall");
        chk("irq_low", {63'b0, mtimer_irq}, 64'd0);

        // Misses, unmapped offset, simultaneous ren/wen
        xact(32'h0300_0000, 32'h1, 4'hF, 0, 1);
        xact(32'h0300_0000, 0, 4'h0, 1, 0);
        chk("miss_nowrite", {63'b0, msw_irq}, 64'd0);
        xact(32'h0200_1234, 32'hDEAD_BEEF, 4'hF, 0, 1);
        xact(32'h0200_1234, 0, 4'h0, 1, 0);
        chk("unmapped_rd", {32'b0, rdata}, 64'd0);
        xact(32'h0200_4004, 0, 4'h0, 1, 0);
        xact(32'h0200_0000, 32'h1, 4'b0001, 1, 1);
        chk("rw_write", {63'b0, msw_irq}, 64'd1);
        chk("rw_rdata", {32'b0, rdata}, 64'd1);

        // Partial byte write
        xact(32'h0200_4000, 32'h0, 4'hF, 0, 1);
        xact(32'h0200_4000, 32'hAABB_CCDD, 4'b0100, 0, 1);
        xact(32'h0200_4000, 0, 4'h0, 1, 0);
        chk("partial", {32'b0, rdata}, 64'h00BB_0000);

        // Reset during RESP
        addr = 32'h0200_4004; wdata = 32'h0; byte_select = 4'hF; wen = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_resp_ready", {63'b0, ready}, 64'd0);
        chk("rst_resp_msw", {63'b0, msw_irq}, 64'd0);
        chk("rst_resp_irq", {63'b0, mtimer_irq}, 64'd0);
        chk("rst_resp_rdata", {32'b0, rdata}, 64'd0);
        wen = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        xact(32'h0200_4000, 0, 4'h0, 1, 0);
        chk("rst_cmp_lo", {32'b0, rdata}, 64'hFFFF_FFFF);
        xact(32'h0200_4004, 0, 4'h0, 1, 0);
        xact(32'h0200_BFF8, 0, 4'h0, 1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 80; i++) begin
            ra = {16'h0200, offs[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
            rd = $urandom;
            if (ra[15:0] >= 16'hBFF8 && $urandom_range(0, 1) == 1) rd = rd & 32'h0000_00FF;
            case ($urandom_range(0, 3))
                0:       xact(ra, rd, 4'($urandom_range(0, 15)), 0, 1);
                1:       xact(ra, rd, 4'($urandom_range(0, 15)), 1, 1);
                2:       idle($urandom_range(0, 3));
                default: xact(ra, rd, 4'h0, 1, 0);
            endcase
            if ($urandom_range(0, 15) == 0) xact(32'h0300_0000 | ra, rd, 4'hF, 1, 0);
            chk_irq_now("irq_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
